dive_scheduler: RTL and testbench

DIVE_SCHEDULER -- requirements
Module: dive_scheduler

---
 rtl/dive_scheduler.sv | 144 ++++++++++++++
 tb/tb_dive_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dive_scheduler.sv
// Dive launch scheduler: periodically picks a live formation enemy
// round-robin and hands it to the enemy datapath with a valid/ack request.
module dive_scheduler #(
   parameter int N_ENEMY    = 16,
   parameter int INTERVAL   = 120,
   parameter int MAX_DIVERS = 2
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       frame_tick,
   input  logic                       active,
   input  logic [N_ENEMY-1:0]         alive,
   input  logic                       dive_ack,
   input  logic                       dive_done,
   input  logic [$clog2(N_ENEMY)-1:0] done_id,
   output logic                       dive_valid,
   output logic [$clog2(N_ENEMY)-1:0] dive_id,
   output logic [N_ENEMY-1:0]         diving,
   output logic [1:0]                 diver_count
);

   localparam int IW = $clog2(N_ENEMY);
   localparam int CW = $clog2(INTERVAL + 1);
   localparam logic [1:0] MAXD = 2'(MAX_DIVERS);
   localparam logic [N_ENEMY-1:0] ONE = N_ENEMY'(1);

   typedef enum logic [1:0] {IDLE, WAIT, SEARCH, REQ} state_t;

   state_t             state;
   state_t             state_nx;
   logic [CW-1:0]      cnt;
   logic               pending;
   logic [IW-1:0]      ptr;
   logic [IW-1:0]      scan;
   logic               cand;
   logic               expire;
   logic               go_search;
   logic               ack;
   logic               withdraw;
   logic [N_ENEMY-1:0] done_mask;
   logic [N_ENEMY-1:0] ack_mask;
   logic [N_ENEMY-1:0] diving_nx;
   logic [IW:0]        pop;

   assign cand      = alive[ptr] & ~diving[ptr];
   assign expire    = frame_tick && (cnt == CW'(INTERVAL - 1));
   assign go_search = (state == WAIT) && pending && (diver_count < MAXD);
   assign ack       = (state == REQ) && dive_ack;
   assign withdraw  = (state == REQ) && !dive_ack && !alive[dive_id];

   // Ack is applied after done/kill clears, so it wins on its own bit.
   always_comb begin
      done_mask = dive_done ? (ONE << done_id) : '0;
      ack_mask  = ack ? (ONE << dive_id) : '0;
      diving_nx = (diving & alive & ~done_mask) | ack_mask;
      pop       = '0;
      for (int i = 0; i < N_ENEMY; i++) begin
         pop = pop + (IW + 1)'(diving_nx[i]);
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (!active) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:   state_nx = WAIT;
            WAIT:   if (go_search) state_nx = SEARCH;
            SEARCH: begin
               if (cand) begin
                  state_nx = REQ;
               end else if (scan == IW'(N_ENEMY - 1)) begin
                  state_nx = WAIT;
               end
            end
            REQ: begin
               if (dive_ack) begin
                  state_nx = WAIT;
               end else if (!alive[dive_id]) begin
                  state_nx = SEARCH;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      dive_valid = (state == REQ);
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         cnt         <= '0;
         pending     <= 1'b0;
         ptr         <= '0;
         scan        <= '0;
         dive_id     <= '0;
         diving      <= '0;
         diver_count <= '0;
      end else if (!active) begin
         cnt         <= '0;
         pending     <= 1'b0;
         scan        <= '0;
         diving      <= '0;
         diver_count <= '0;
      end else begin
         // The interval keeps its cadence while a search or request runs.
         if (state != IDLE && frame_tick) begin
            cnt <= expire ? '0 : cnt + CW'(1);
         end
         pending     <= (state != IDLE && expire) | (pending & ~go_search);
         diving      <= diving_nx;
         diver_count <= pop[1:0];
         if (go_search) begin
            scan <= '0;
         end
         if (state == SEARCH) begin
            if (cand) begin
               dive_id <= ptr;
            end else begin
               ptr  <= ptr + IW'(1);
               scan <= scan + IW'(1);
            end
         end
         if (ack || withdraw) begin
            ptr <= dive_id + IW'(1);
         end
         if (withdraw) begin
            scan <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dive_scheduler.sv
// Directed bench for dive_scheduler with a short launch interval.
module tb_dive_scheduler;

   logic        clk;
   logic        rst;
   logic        frame_tick;
   logic        active;
   logic [15:0] alive;
   logic        dive_ack;
   logic        dive_done;
   logic [3:0]  done_id;
   logic        dive_valid;
   logic [3:0]  dive_id;
   logic [15:0] diving;
   logic [1:0]  diver_count;

   int total;
   int bad;

   dive_scheduler #(
      .N_ENEMY(16),
      .INTERVAL(4),
      .MAX_DIVERS(2)
   ) dut (
      .Clk(clk),
      .Reset(rst),
      .frame_tick(frame_tick),
      .active(active),
      .alive(alive),
      .dive_ack(dive_ack),
      .dive_done(dive_done),
      .done_id(done_id),
      .dive_valid(dive_valid),
      .dive_id(dive_id),
      .diving(diving),
      .diver_count(diver_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
      end
   endtask

   task automatic wait_valid(input int lim, output int n);
      n = 0;
      while (!dive_valid && n < lim) begin
         step();
         n++;
      end
   endtask

   task automatic count_valid(input int cyc, output int hits);
      hits = 0;
      for (int i = 0; i < cyc; i++) begin
         step();
         if (dive_valid) hits++;
      end
   endtask

   task automatic do_reset();
      active = 1'b0;
      rst    = 1'b0;
      step();
      rst    = 1'b1;
      active = 1'b1;
      step();
   endtask

   task automatic ack_once();
      dive_ack = 1'b1;
      step();
      dive_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      active = 1'b1;
      alive = 16'hFFFF;
      step();
      step();
      total += 4;
      if (dive_valid !== 1'b0) begin
         bad++; $display("FAIL reset_valid got=%b want=0", dive_valid);
      end
      if (dive_id !== 4'd0) begin
         bad++; $display("FAIL reset_id got=%0d want=0", dive_id);
      end
      if (diving !== 16'h0) begin
         bad++; $display("FAIL reset_diving got=%h want=0000", diving);
      end
      if (diver_count !== 2'd0) begin
         bad++; $display("FAIL reset_count got=%0d want=0", diver_count);
      end
      rst = 1'b1;
   endtask

   task automatic test_first_dive();
      int n;
      int hits;
      alive = 16'hFFFF;
      do_reset();
      ticks(4);
      wait_valid(20, n);
      total += 7;
      if (n !== 2) begin
         bad++; $display("FAIL first_latency got=%0d want=2", n);
      end
      if (dive_id !== 4'd0) begin
         bad++; $display("FAIL first_id got=%0d want=0", dive_id);
      end
      ack_once();
      if (dive_valid !== 1'b0) begin
         bad++; $display("FAIL first_ack_valid got=%b want=0", dive_valid);
      end
      if (diving !== 16'h0001) begin
         bad++; $display("FAIL first_diving got=%h want=0001", diving);
      end
      if (diver_count !== 2'd1) begin
         bad++; $display("FAIL first_count got=%0d want=1", diver_count);
      end
      ticks(3);
      count_valid(5, hits);
      if (hits !== 0) begin
         bad++; $display("FAIL wrap_early got=%0d want=0", hits);
      end
      ticks(1);
      wait_valid(20, n);
      if (n !== 2 || dive_id !== 4'd1) begin
         bad++; $display("FAIL second_launch n=%0d id=%0d want n=2 id=1", n, dive_id);
      end
   endtask

   task automatic test_scan_latency();
      int n;
      alive = 16'h0100;
      do_reset();
      ticks(4);
      wait_valid(30, n);
      total += 3;
      if (n !== 10) begin
         bad++; $display("FAIL scan_latency got=%0d want=10", n);
      end
      if (dive_id !== 4'd8) begin
         bad++; $display("FAIL scan_id got=%0d want=8", dive_id);
      end
      ack_once();
      if (diving !== 16'h0100 || diver_count !== 2'd1) begin
         bad++; $display("FAIL scan_ack diving=%h cnt=%0d want 0100/1", diving, diver_count);
      end
   endtask

   task automatic test_max_divers();
      int n;
      int hits;
      alive = 16'hFFFF;
      do_reset();
      ticks(4);
      wait_valid(20, n);
      ack_once();
      ticks(4);
      wait_valid(20, n);
      ack_once();
      total += 8;
      if (diving !== 16'h0003 || diver_count !== 2'd2) begin
         bad++; $display("FAIL max_two diving=%h cnt=%0d want 0003/2", diving, diver_count);
      end
      ticks(4);
      count_valid(20, hits);
      ticks(4);
      if (hits !== 0 || dive_valid !== 1'b0) begin
         bad++; $display("FAIL max_block got=%0d want=0", hits);
      end
      dive_done = 1'b1;
      done_id   = 4'd0;
      step();
      dive_done = 1'b0;
      if (diving !== 16'h0002 || diver_count !== 2'd1) begin
         bad++; $display("FAIL done_clear diving=%h cnt=%0d want 0002/1", diving, diver_count);
      end
      wait_valid(17, n);
      if (n !== 2) begin
         bad++; $display("FAIL done_latency got=%0d want=2", n);
      end
      if (dive_id !== 4'd2) begin
         bad++; $display("FAIL done_id got=%0d want=2", dive_id);
      end
      ack_once();
      if (diving !== 16'h0006 || diver_count !== 2'd2) begin
         bad++; $display("FAIL relaunch diving=%h cnt=%0d want 0006/2", diving, diver_count);
      end
      dive_done = 1'b1;
      done_id   = 4'd1;
      step();
      done_id   = 4'd9;
      step();
      dive_done = 1'b0;
      if (diving !== 16'h0004 || diver_count !== 2'd1) begin
         bad++; $display("FAIL done_ignore diving=%h cnt=%0d want 0004/1", diving, diver_count);
      end
      count_valid(20, hits);
      if (hits !== 0) begin
         bad++; $display("FAIL single_launch got=%0d want=0", hits);
      end
   endtask

   task automatic test_withdraw();
      int n;
      alive = 16'hFFE0;
      do_reset();
      ticks(4);
      wait_valid(20, n);
      total += 7;
      if (dive_id !== 4'd5) begin
         bad++; $display("FAIL wd_first_id got=%0d want=5", dive_id);
      end
      alive = 16'hFFC0;
      step();
      if (dive_valid !== 1'b0) begin
         bad++; $display("FAIL wd_drop got=%b want=0", dive_valid);
      end
      step();
      if (dive_valid !== 1'b1 || dive_id !== 4'd6) begin
         bad++; $display("FAIL wd_next valid=%b id=%0d want 1/6", dive_valid, dive_id);
      end
      if (diving !== 16'h0) begin
         bad++; $display("FAIL wd_no_set got=%h want=0000", diving);
      end
      dive_ack = 1'b1;
      alive    = 16'hFF80;
      step();
      dive_ack = 1'b0;
      if (diving !== 16'h0040 || diver_count !== 2'd1) begin
         bad++; $display("FAIL ack_wins diving=%h cnt=%0d want 0040/1", diving, diver_count);
      end
      step();
      if (diving !== 16'h0 || diver_count !== 2'd0) begin
         bad++; $display("FAIL kill diving=%h cnt=%0d want 0000/0", diving, diver_count);
      end
      ack_once();
      if (diving !== 16'h0 || dive_valid !== 1'b0) begin
         bad++; $display("FAIL stray_ack diving=%h valid=%b want 0000/0", diving, dive_valid);
      end
   endtask

   task automatic test_empty_scan();
      int n;
      int hits;
      alive = 16'h0000;
      do_reset();
      ticks(4);
      count_valid(30, hits);
      total += 3;
      if (hits !== 0) begin
         bad++; $display("FAIL empty_valid got=%0d want=0", hits);
      end
      alive = 16'hFFFF;
      count_valid(10, hits);
      if (hits !== 0) begin
         bad++; $display("FAIL empty_dropped got=%0d want=0", hits);
      end
      ticks(4);
      wait_valid(20, n);
      if (n !== 2 || dive_id !== 4'd0) begin
         bad++; $display("FAIL empty_recover n=%0d id=%0d want n=2 id=0", n, dive_id);
      end
   endtask

   task automatic test_deactivate();
      int n;
      alive = 16'hFFFF;
      do_reset();
      ticks(4);
      wait_valid(20, n);
      ack_once();
      ticks(4);
      wait_valid(20, n);
      total += 4;
      if (dive_valid !== 1'b1 || diving !== 16'h0001) begin
         bad++; $display("FAIL deact_setup valid=%b diving=%h want 1/0001", dive_valid, diving);
      end
      active = 1'b0;
      step();
      if (diving !== 16'h0 || diver_count !== 2'd0 || dive_valid !== 1'b0) begin
         bad++; $display("FAIL deact diving=%h cnt=%0d valid=%b want 0000/0/0", diving, diver_count, dive_valid);
      end
      active = 1'b1;
      step();
      ticks(4);
      wait_valid(20, n);
      if (dive_valid !== 1'b1 || dive_id !== 4'd1) begin
         bad++; $display("FAIL rst_setup valid=%b id=%0d want 1/1", dive_valid, dive_id);
      end
      rst      = 1'b0;
      dive_ack = 1'b1;
      step();
      rst      = 1'b1;
      dive_ack = 1'b0;
      if (dive_valid !== 1'b0 || diving !== 16'h0) begin
         bad++; $display("FAIL rst_mid_req valid=%b diving=%h want 0/0000", dive_valid, diving);
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst        = 1'b0;
      frame_tick = 1'b0;
      active     = 1'b0;
      alive      = 16'h0;
      dive_ack   = 1'b0;
      dive_done  = 1'b0;
      done_id    = 4'd0;
      test_reset();
      test_first_dive();
      test_scan_latency();
      test_max_divers();
      test_withdraw();
      test_empty_scan();
      test_deactivate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
